// File: rtl/grant_priority_arbiter.sv
// grant_priority_arbiter: 8-way stateful arbiter (index 7 highest, optional round robin)
// that holds a registered grant until release, with an optional hold-time limit.
module grant_priority_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_rr_mode,
  input  logic [7:0] i_req,
  output logic [7:0] o_gnt,
  output logic [2:0] o_gnt_id,
  output logic       o_gnt_valid,
  output logic       o_timeout
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_gnt, w_gnt_nxt;
  logic [2:0]      r_gnt_id, w_gnt_id_nxt;
  logic            r_gnt_valid, w_gnt_valid_nxt;
  logic            r_timeout, w_timeout_nxt;
  logic [2:0]      r_last_id, w_last_id_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]      r_mask, w_mask_nxt, w_mask_set;
  logic [7:0]      w_elig;
  logic [2:0]      w_fix_id, w_rr_id, w_win_id;

  assign w_elig = i_req & ~r_mask;

  // Winner candidates: fixed picks the highest eligible index; round robin walks
  // down from last_id-1 and wraps, so the previous owner is checked last.
  always_comb begin
    logic [2:0] idx;
    w_fix_id = 3'd0;
    w_rr_id  = 3'd0;
    idx      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_fix_id = w_elig[i] ? 3'(i) : w_fix_id;
    end
    for (int off = 8; off >= 1; off--) begin
      idx     = r_last_id - 3'(off);
      w_rr_id = w_elig[idx] ? idx : w_rr_id;
    end
    w_win_id = i_rr_mode ? w_rr_id : w_fix_id;
  end

  // Next-state and next-output logic for the IDLE/GRANT/RECOVER controller.
  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    w_last_id_nxt   = r_last_id;
    w_cnt_nxt       = r_cnt;
    w_mask_set      = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (i_en && (w_elig != 8'h00)) begin
          w_gnt_nxt       = 8'h01 << w_win_id;
          w_gnt_id_nxt    = w_win_id;
          w_gnt_valid_nxt = 1'b1;
          w_last_id_nxt   = w_win_id;
          w_cnt_nxt       = '0;
          w_state_nxt     = S_GRANT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        w_cnt_nxt = r_cnt + CW'(1);
        // Release is checked first so an owner leaving on its last cycle is not penalised.
        if (!i_req[r_gnt_id] || !i_en) begin
          w_gnt_nxt       = 8'h00;
          w_gnt_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if ((MAX_HOLD != 0) && (r_cnt == HOLD_LAST)) begin
          w_gnt_nxt       = 8'h00;
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = 1'b1;
          w_mask_set      = 8'h01 << r_gnt_id;
          w_state_nxt     = S_RECOVER;
        end else begin
          w_state_nxt = S_GRANT;
        end
      end
      S_RECOVER: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gnt_nxt       = 8'h00;
        w_gnt_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
    w_mask_nxt = (r_mask | w_mask_set) & i_req;
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= 8'h00;
      r_gnt_id    <= 3'd0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_last_id   <= 3'd0;
      r_cnt       <= '0;
      r_mask      <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_last_id   <= w_last_id_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mask      <= w_mask_nxt;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_id    = r_gnt_id;
  assign o_gnt_valid = r_gnt_valid;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_grant_priority_arbiter.sv
// Scoreboard bench for grant_priority_arbiter: an owner-based reference model pushes the
// expected outputs per edge; a monitor pops and compares them just after each edge.
module tb_grant_priority_arbiter;
  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rr = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] o_gnt;
  logic [2:0] o_gnt_id;
  logic       o_gnt_valid;
  logic       o_timeout;

  always #5 clk = ~clk;

  grant_priority_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_rr_mode(rr), .i_req(req),
    .o_gnt(o_gnt), .o_gnt_id(o_gnt_id), .o_gnt_valid(o_gnt_valid), .o_timeout(o_timeout)
  );

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       v;
    logic       t;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] glog[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the resource and for how many cycles it has been shown.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 0;
  int m_id    = 0;
  bit m_rec   = 1'b0;
  bit m_tmo   = 1'b0;
  bit m_ban[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_owner = -1; m_held = 0; m_last = 0; m_id = 0; m_rec = 1'b0; m_tmo = 1'b0;
    for (int i = 0; i < 8; i++) m_ban[i] = 1'b0;
  endfunction

  function automatic void m_edge(input bit e, input bit r, input logic [7:0] q);
    m_tmo = 1'b0;
    if (m_owner >= 0) begin
      if (!q[m_owner] || !e) m_owner = -1;
      else if (MAX_HOLD > 0 && m_held == MAX_HOLD) begin
        m_tmo = 1'b1; m_ban[m_owner] = 1'b1; m_owner = -1; m_rec = 1'b1;
      end else m_held++;
    end else if (m_rec) begin
      m_rec = 1'b0;
    end else if (e) begin
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = r ? (m_last - k + 16) % 8 : 8 - k;
        if (m_owner < 0 && q[c] && !m_ban[c]) begin
          m_owner = c; m_held = 1; m_last = c; m_id = c;
        end
      end
    end
    for (int i = 0; i < 8; i++) if (!q[i]) m_ban[i] = 1'b0;
  endfunction

  task automatic step(input bit e, input bit r, input logic [7:0] q);
    exp_t x;
    en = e; rr = r; req = q;
    m_edge(e, r, q);
    x.gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    x.id  = 3'(m_id);
    x.v   = (m_owner >= 0);
    x.t   = m_tmo;
    exp_q.push_back(x);
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", int'(o_gnt), 0);
    chk("rst_gnt_valid", int'(o_gnt_valid), 0);
    chk("rst_timeout", int'(o_timeout), 0);
    m_reset();
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare DUT outputs against the scoreboard just after each edge.
  logic prev_v = 1'b0;
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt", int'(o_gnt), int'(e.gnt));
      chk("gnt_id", int'(o_gnt_id), int'(e.id));
      chk("gnt_valid", int'(o_gnt_valid), int'(e.v));
      chk("timeout", int'(o_timeout), int'(e.t));
    end
    if (o_gnt_valid && !prev_v) glog.push_back(o_gnt_id);
    prev_v = o_gnt_valid;
  end

  initial begin
    m_reset();
    #12;
    chk("reset_gnt", int'(o_gnt), 0);
    chk("reset_gnt_id", int'(o_gnt_id), 0);
    chk("reset_valid", int'(o_gnt_valid), 0);
    chk("reset_timeout", int'(o_timeout), 0);
    rst_n = 1'b1;

    // Fixed priority: 5 wins, then 3 after one idle cycle.
    step(1'b1, 1'b0, 8'h2A);
    step(1'b1, 1'b0, 8'h2A);
    step(1'b1, 1'b0, 8'h0A);
    step(1'b1, 1'b0, 8'h0A);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // Round robin from reset, every owner releases after 2 cycles.
    async_reset();
    glog.delete();
    for (int s = 0; s < 30; s++) begin
      logic [7:0] q;
      q = 8'hFF;
      if (m_owner >= 0 && m_held == 2) q[m_owner] = 1'b0;
      step(1'b1, 1'b1, q);
    end
    chk("rr_grants_seen", int'(glog.size() >= 9), 1);
    for (int i = 0; i < 9; i++) begin
      if (i < glog.size()) chk("rr_order", int'(glog[i]), (7 - i + 8) % 8);
    end
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);

    // Hold limit with req[2] held, then drop for one cycle and re-raise.
    repeat (8) step(1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // Release in the last allowed cycle beats the limit.
    for (int s = 0; s < 10 && !(m_owner == 2 && m_held == MAX_HOLD); s++) step(1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 8'h04);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // Enable dropped mid-grant, then restored.
    step(1'b1, 1'b0, 8'h10);
    step(1'b1, 1'b0, 8'h10);
    repeat (3) step(1'b0, 1'b0, 8'h10);
    step(1'b1, 1'b0, 8'h10);
    step(1'b1, 1'b0, 8'h10);
    step(1'b1, 1'b0, 8'h00);

    // Randomized traffic; owners usually keep their request up.
    repeat (400) begin
      logic [7:0] q;
      q = 8'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 3) != 0) q[m_owner] = 1'b1;
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), q);
    end

    // Async reset in the middle of a grant; first rr grant afterwards goes to 7.
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h40);
    step(1'b1, 1'b0, 8'h40);
    async_reset();
    step(1'b1, 1'b1, 8'h81);
    chk("rst_rr_first_id", int'(o_gnt_id), 7);
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/grant_priority_arbiter.md
# grant_priority_arbiter

Sequential arbiter that shares one 8-input resource among eight requesters, using the same ordering as the 8-to-3 priority encoder datapath (index 7 highest). It registers a one-hot grant plus encoded grant ID, holds the grant until the owner releases it, and enforces a maximum hold time. An optional round-robin mode gives fair access. It sits in front of the encoded-select datapath, replacing the purely combinational encode with a handshaked, stateful owner.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one owner may hold the grant; 0 disables the limit.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  arbiter enable; low forces release and blocks new grants.
- rr_mode  in  1  0 = fixed priority (7 highest); 1 = round robin.
- req  in  8  request vector; req[i] stays high while requester i wants or holds the resource.
- gnt  out  8  registered one-hot grant; all-zero when idle.
- gnt_id  out  3  registered index of the granted requester; valid only when gnt_valid = 1.
- gnt_valid  out  1  registered; equals |gnt.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State machine: IDLE, GRANT, RECOVER.
- Internal state: last_id (3 b), hold counter (width clog2(MAX_HOLD+1)), mask (8 b).
- Eligible set: req & ~mask.
- IDLE:
  - If en = 1 and the eligible set is non-zero, select a winner, load gnt/gnt_id, set gnt_valid, clear the counter, update last_id, and go to GRANT.
  - Otherwise stay in IDLE.
- Winner selection:
  - Fixed mode: highest eligible index.
  - Round-robin mode: search descending from last_id-1, wrapping 0 to 7, ending at last_id. The previous owner is therefore lowest priority.
- GRANT:
  - The counter increments every cycle.
  - If req[gnt_id] = 0 or en = 0: clear gnt and gnt_valid, go to IDLE. timeout stays 0.
  - Else if MAX_HOLD != 0 and the counter reaches MAX_HOLD-1: clear the grant, pulse timeout, set mask[gnt_id], go to RECOVER.
  - Else hold all outputs unchanged.
  - Release takes precedence over timeout in the same cycle.
- RECOVER: one cycle with no grant, then IDLE.
- Mask: mask[i] clears on any edge where req[i] = 0, in all states. A timed-out requester must drop req for at least one cycle before it can win again.
- Changes to req other than the owner's bit during GRANT are ignored. No preemption by higher-priority requesters.
- rr_mode is sampled only when a winner is selected in IDLE.
- gnt_id keeps its last value while idle; consumers qualify it with gnt_valid.

## Timing
- Reset values (async assert, sync-clean deassert): state IDLE, gnt 0, gnt_id 0, gnt_valid 0, timeout 0, last_id 0, counter 0, mask 0.
- Because last_id resets to 0, the first round-robin search starts at index 7.
- Grant latency: req sampled high at edge k, gnt visible after edge k. This is one cycle.
- Release latency: owner drops req before edge k, gnt clears after edge k. The earliest re-grant is after edge k+1, giving at least one idle cycle between owners.
- Hold limit: gnt is high for exactly MAX_HOLD cycles. timeout is high during the first cycle after revocation. The next grant is no earlier than 2 cycles after revocation.
- en deasserted: the grant clears after the next edge. While en = 0, the mask still clears normally.
- Reset mid-grant: all outputs clear immediately and the mask and last_id are lost.

## Test plan
- Fixed priority, rr_mode = 0, req = 8'b0010_1010 at cycle 0:
  - gnt = 8'b0010_0000 and gnt_id = 5 after one edge.
  - Drop req[5]: gnt clears, idle 1 cycle, then gnt_id = 3.
- Round robin, rr_mode = 1, req = 8'hFF constantly, each owner releases after 2 cycles:
  - Grant order is 7, 6, 5, …, 0, 7.
  - No index repeats before all 8 have been served.
- Timeout, MAX_HOLD = 4, req[2] held high alone:
  - gnt[2] is high exactly 4 cycles, then timeout pulses once.
  - No re-grant while req[2] stays high.
  - Drop req[2] for 1 cycle and re-raise it: granted again.
- Simultaneous release and limit, MAX_HOLD = 4: owner drops req in its 4th grant cycle -> timeout = 0 and mask bit not set.
- en low mid-grant: gnt clears next edge. With en low and req nonzero, gnt stays 0. After en rises, a grant follows in 1 cycle.
- Async reset: assert rst_n = 0 mid-GRANT between edges -> gnt, gnt_valid and timeout go 0 immediately. After release, the first rr grant with req = 8'h81 goes to 7.
